// File: rtl/i281_code_fetch.sv
// i281_code_fetch: copies the 16-word code ROM into a writable code RAM, then runs PC/IR fetch and branch.
// Optional macro I281_PC_WRAP_TRAP_EN: a fetch at pc=15 enters HALT and raises a sticky wrap_trap.
`default_nettype none

module i281_code_fetch #(
  parameter int WORDS = 16,
  parameter int WIDTH = 16
) (
  input  logic                   Clock_i,
  input  logic                   Reset_i,
  input  logic [WORDS*WIDTH-1:0] code_words_i,
  input  logic                   reboot_i,
  input  logic                   fetch_en_i,
  input  logic                   branch_taken_i,
  input  logic [7:0]             branch_offset_i,
  input  logic                   pgm_we_i,
  input  logic [3:0]             pgm_addr_i,
  input  logic [WIDTH-1:0]       pgm_data_i,
  output logic [WIDTH-1:0]       instr_o,
  output logic                   instr_valid_o,
  output logic [3:0]             pc_o,
  output logic                   boot_done_o,
  output logic                   wrap_trap_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         pc_q, pc_d;
  logic [WIDTH-1:0]   instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               trap_q, trap_d;
  logic [WIDTH-1:0]   mem_q [WORDS];

  logic               boot_we;
  logic               pgm_we;
  logic [WIDTH-1:0]   fetch_data;
  logic [3:0]         branch_pc;
  logic               unused_offset_hi;

  // Only the low 4 bits of the sign-extended sum survive the mod-16 wrap.
  assign branch_pc        = pc_q + branch_offset_i[3:0];
  assign unused_offset_hi = ^branch_offset_i[7:4];

  assign boot_we    = (state_q == S_BOOT);
  assign pgm_we     = (state_q == S_RUN) && pgm_we_i && !reboot_i;
  assign fetch_data = (pgm_we && (pgm_addr_i == pc_q)) ? pgm_data_i : mem_q[pc_q];

  always_ff @(posedge Clock_i) begin
    if (!Reset_i) begin
      if (boot_we) begin
        mem_q[cnt_q] <= code_words_i[cnt_q*WIDTH +: WIDTH];
      end else if (pgm_we) begin
        mem_q[pgm_addr_i] <= pgm_data_i;
      end
    end
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q <= S_BOOT;
      cnt_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    trap_d  = trap_q;
    case (state_q)
      S_BOOT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_RUN;
      end
      S_RUN: begin
        if (reboot_i) begin
          state_d = S_BOOT;
          cnt_d   = '0;
          pc_d    = '0;
          trap_d  = 1'b0;
        end else if (branch_taken_i) begin
          pc_d = branch_pc;
        end else if (fetch_en_i) begin
          instr_d = fetch_data;
          pc_d    = pc_q + 4'd1;
          valid_d = 1'b1;
`ifdef I281_PC_WRAP_TRAP_EN
          if (pc_q == 4'd15) begin
            state_d = S_HALT;
            trap_d  = 1'b1;
          end
`endif
        end
      end
      S_HALT: begin
        if (reboot_i) begin
          state_d = S_BOOT;
          cnt_d   = '0;
          pc_d    = '0;
          trap_d  = 1'b0;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign boot_done_o   = (state_q != S_BOOT);
`ifdef I281_PC_WRAP_TRAP_EN
  assign wrap_trap_o   = trap_q;
`else
  assign wrap_trap_o   = 1'b0;
`endif

endmodule

`default_nettype wire
